// File: rtl/dpwm_pkg.sv
// Shared definitions for the buck DPWM sequencer: state codes and default sizing.
package dpwm_pkg;

    localparam int DPWM_WIDTH      = 10;
    localparam int DPWM_PERIOD_MAX = 1023;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_SOFTSTART = 2'd1;
    localparam logic [1:0] ST_RUN       = 2'd2;
    localparam logic [1:0] ST_FAULT     = 2'd3;

    // True in the states where the period counter runs and duty is driven.
    function automatic logic is_active(input logic [1:0] st);
        return (st == ST_SOFTSTART) || (st == ST_RUN);
    endfunction

endpackage

// File: rtl/dpwm_period_counter.sv
// Main DPWM period counter: counts 0..terminal while run is high, clear forces 0.
// wrap flags the last cycle of a period, when the counter will return to 0.
module dpwm_period_counter
    import dpwm_pkg::*;
#(
    parameter int WIDTH = DPWM_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             run,
    input  logic [WIDTH-1:0] terminal,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    // Free-running period count, held while stopped, forced to zero on clear.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset || clear) begin
            count <= '0;
        end else if (run) begin
            count <= (count == terminal) ? '0 : count + 1'b1;
        end
    end

    // A clear on the terminal cycle is a shutdown, not a period boundary.
    assign wrap = run && !clear && (count == terminal);

endmodule

// File: rtl/dpwm_duty_sequencer.sv
// Buck DPWM duty sequencer: owns the run/soft-start/fault FSM, the duty command
// handshake and the target/pending/duty registers. Duty changes only at period wrap.
// Optional feature: define DPWM_SOFTSTART_EN to ramp duty up by RAMP_STEP per period
// after enable; otherwise IDLE goes straight to RUN and loads the target on entry.
module dpwm_duty_sequencer
    import dpwm_pkg::*;
#(
    parameter int WIDTH      = DPWM_WIDTH,
    parameter int PERIOD_MAX = DPWM_PERIOD_MAX,
    parameter int DUTY_MAX   = 1023,
    parameter int RAMP_STEP  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             fault,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic [WIDTH-1:0] cnt_out,
    output logic [WIDTH-1:0] duty_out,
    output logic             period_start,
    output logic [1:0]       state_out
);

    localparam logic [WIDTH-1:0] TERMINAL   = PERIOD_MAX[WIDTH-1:0];
    localparam logic [WIDTH-1:0] DUTY_LIMIT = DUTY_MAX[WIDTH-1:0];
    localparam logic [WIDTH:0]   STEP       = RAMP_STEP[WIDTH:0];

    logic [1:0]       state, state_nxt;
    logic [WIDTH-1:0] target, target_nxt;
    logic [WIDTH-1:0] duty_nxt;
    logic             pending, pending_nxt;
    logic             ready_nxt;
    logic             accept;
    logic [WIDTH-1:0] duty_clamped;
    logic             active;
    logic             shutdown;
    logic             wrap;
    logic [WIDTH:0]   ramp_sum;
    logic [WIDTH-1:0] ramp_val;
    logic             ramp_done;

    assign active       = is_active(state);
    assign accept       = duty_valid && duty_ready;
    assign duty_clamped = (duty_in > DUTY_LIMIT) ? DUTY_LIMIT : duty_in;
    // Fault from anywhere, or enable dropping while running, zeroes duty and counter at once.
    assign shutdown     = fault || (active && !enable);

    dpwm_period_counter #(
        .WIDTH(WIDTH)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (shutdown),
        .run      (active),
        .terminal (TERMINAL),
        .count    (cnt_out),
        .wrap     (wrap)
    );

    // Soft-start step: one extra bit on the sum so a step past full scale cannot wrap.
    always_comb begin
        ramp_sum = {1'b0, duty_out} + STEP;
        if (target < duty_out) begin
            ramp_val = target;
        end else if (ramp_sum > {1'b0, target}) begin
            ramp_val = target;
        end else begin
            ramp_val = ramp_sum[WIDTH-1:0];
        end
    end

    assign ramp_done = (ramp_val == target);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic; fault overrides everything.
    always_comb begin
        // NOTE: default assignment first so every path drives the signal and no latch is inferred.
        state_nxt = state;
        if (fault) begin
            state_nxt = ST_FAULT;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable) begin
`ifdef DPWM_SOFTSTART_EN
                        state_nxt = ST_SOFTSTART;
`else
                        state_nxt = ST_RUN;
`endif
                    end
                end
                ST_SOFTSTART: begin
                    if (!enable) begin
                        state_nxt = ST_IDLE;
                    end else if (wrap && ramp_done) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_FAULT: begin
                    if (!enable) begin
                        state_nxt = ST_IDLE;
                    end
                end
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        state_out    = state;
        period_start = active && (cnt_out == '0);
    end

    // Duty datapath: a wrap sees the pre-accept pending/target, an accept re-arms pending.
    always_comb begin
        target_nxt  = target;
        pending_nxt = pending;
        duty_nxt    = duty_out;

        if (accept) begin
            target_nxt = duty_clamped;
        end

        case (state)
            ST_IDLE: begin
                // Direct entry to RUN loads the stored target immediately.
                if (state_nxt == ST_RUN) begin
                    duty_nxt = target;
                end
            end
            ST_SOFTSTART: begin
                if (wrap) begin
                    duty_nxt    = ramp_val;
                    pending_nxt = 1'b0;
                end
                if (accept) begin
                    pending_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                if (wrap && pending) begin
                    duty_nxt    = target;
                    pending_nxt = 1'b0;
                end
                if (accept) begin
                    pending_nxt = 1'b1;
                end
            end
            ST_FAULT: begin
            end
        endcase

        if (shutdown) begin
            duty_nxt = '0;
        end
        if (fault) begin
            pending_nxt = 1'b0;
        end

        ready_nxt = !pending_nxt && (state_nxt != ST_FAULT);
    end

    // Duty datapath registers; ready is registered from the next-cycle view of pending/state.
    always_ff @(posedge clk) begin
        if (reset) begin
            target     <= '0;
            pending    <= 1'b0;
            duty_out   <= '0;
            duty_ready <= 1'b0;
        end else begin
            target     <= target_nxt;
            pending    <= pending_nxt;
            duty_out   <= duty_nxt;
            duty_ready <= ready_nxt;
        end
    end

endmodule

// File: tb/tb_dpwm_duty_sequencer.sv
// Self-checking bench for dpwm_duty_sequencer: directed scenarios plus randomized
// traffic compared against a behavioural reference model. Builds with or without
// DPWM_SOFTSTART_EN.
module tb_dpwm_duty_sequencer;

    localparam int P_MAX = 1023;
    localparam int D_MAX = 1023;
    localparam int STEP  = 8;
`ifdef DPWM_SOFTSTART_EN
    localparam int ENTRY_STATE = 1;
`else
    localparam int ENTRY_STATE = 2;
`endif

    logic       clk = 1'b0;
    logic       reset, enable, fault, duty_valid;
    logic [9:0] duty_in;
    logic       duty_ready, period_start;
    logic [9:0] cnt_out, duty_out;
    logic [1:0] state_out;

    // Second instance: wider duty path with a lower clamp and a short period.
    logic        c_reset, c_enable, c_valid, c_ready, c_ps;
    logic        c_fault = 1'b0;
    logic [10:0] c_duty_in, c_cnt, c_duty_out;
    logic [1:0]  c_state;

    int errors = 0;
    int checks = 0;
    int cur_duty;

    // Reference model state.
    int m_state = 0, m_cnt = 0, m_duty = 0, m_target = 0;
    bit m_pending = 0, m_ready = 0;

    always #5 clk = ~clk;

    dpwm_duty_sequencer #(
        .WIDTH(10), .PERIOD_MAX(P_MAX), .DUTY_MAX(D_MAX), .RAMP_STEP(STEP)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .fault(fault),
        .duty_in(duty_in), .duty_valid(duty_valid), .duty_ready(duty_ready),
        .cnt_out(cnt_out), .duty_out(duty_out), .period_start(period_start),
        .state_out(state_out)
    );

    dpwm_duty_sequencer #(
        .WIDTH(11), .PERIOD_MAX(15), .DUTY_MAX(1000), .RAMP_STEP(STEP)
    ) dut_clamp (
        .clk(clk), .reset(c_reset), .enable(c_enable), .fault(c_fault),
        .duty_in(c_duty_in), .duty_valid(c_valid), .duty_ready(c_ready),
        .cnt_out(c_cnt), .duty_out(c_duty_out), .period_start(c_ps),
        .state_out(c_state)
    );

    // Behavioural model of the main instance, stepped on every rising edge.
    always @(posedge clk) begin : ref_model
        int n_state, n_cnt, n_duty, n_target, clamp;
        bit n_pending, n_ready, acc;
        n_state = m_state; n_cnt = m_cnt; n_duty = m_duty;
        n_target = m_target; n_pending = m_pending;
        if (reset) begin
            n_state = 0; n_cnt = 0; n_duty = 0; n_target = 0; n_pending = 0; n_ready = 0;
        end else begin
            acc   = duty_valid && m_ready;
            clamp = (int'(duty_in) > D_MAX) ? D_MAX : int'(duty_in);
            if (acc) n_target = clamp;
            if (fault) begin
                n_state = 3; n_duty = 0; n_cnt = 0; n_pending = 0;
            end else if (m_state == 0) begin
                if (enable) begin
                    n_state = ENTRY_STATE;
                    if (ENTRY_STATE == 2) n_duty = m_target;
                end
            end else if (m_state == 3) begin
                if (!enable) n_state = 0;
            end else if (!enable) begin
                n_state = 0; n_duty = 0; n_cnt = 0;
                if (acc) n_pending = 1;
            end else begin
                n_cnt = (m_cnt + 1) % (P_MAX + 1);
                if (m_cnt == P_MAX) begin
                    if (m_state == 2) begin
                        if (m_pending) begin
                            n_duty = m_target; n_pending = 0;
                        end
                    end else begin
                        if (m_target < m_duty) n_duty = m_target;
                        else n_duty = (m_duty + STEP < m_target) ? m_duty + STEP : m_target;
                        if (n_duty == m_target) n_state = 2;
                        n_pending = 0;
                    end
                end
                if (acc) n_pending = 1;
            end
            n_ready = !n_pending && (n_state != 3);
        end
        m_state   <= n_state;
        m_cnt     <= n_cnt;
        m_duty    <= n_duty;
        m_target  <= n_target;
        m_pending <= n_pending;
        m_ready   <= n_ready;
    end

    // Advance to the negedge where cnt_out shows v, bounded by budget cycles.
    task automatic wait_cnt(input int v, input int budget);
        int n = 0;
        while (cnt_out !== 10'(v) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (cnt_out !== 10'(v)) begin
            errors++; checks++;
            $display("FAIL wait_cnt: cnt_out=%0d never reached %0d", cnt_out, v);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; enable = 1'b0; fault = 1'b0; duty_valid = 1'b0; duty_in = '0;
        repeat (3) @(negedge clk);
        checks++; if (cnt_out !== 10'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", cnt_out); end
        checks++; if (duty_out !== 10'd0) begin errors++; $display("FAIL reset_duty: got %0d exp 0", duty_out); end
        checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", state_out); end
        checks++; if (duty_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b exp 0", duty_ready); end
        checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL reset_pstart: got %0b exp 0", period_start); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (duty_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %0b exp 1", duty_ready); end
    endtask

`ifdef DPWM_SOFTSTART_EN
    task automatic test_enable_run;
        int exp_seq[3] = '{8, 16, 20};
        duty_in = 10'd20; duty_valid = 1'b1;
        @(negedge clk);
        duty_valid = 1'b0; enable = 1'b1;
        @(negedge clk);
        checks++; if (state_out !== 2'd1) begin errors++; $display("FAIL ss_entry_state: got %0d exp 1", state_out); end
        checks++; if (duty_out !== 10'd0) begin errors++; $display("FAIL ss_entry_duty: got %0d exp 0", duty_out); end
        for (int i = 0; i < 3; i++) begin
            wait_cnt(P_MAX, 1100);
            checks++; if (state_out !== 2'd1) begin errors++; $display("FAIL ss_pre_wrap_state: got %0d exp 1", state_out); end
            @(negedge clk);
            checks++; if (duty_out !== 10'(exp_seq[i])) begin errors++; $display("FAIL ss_ramp: got %0d exp %0d", duty_out, exp_seq[i]); end
            checks++; if (state_out !== ((i == 2) ? 2'd2 : 2'd1)) begin errors++; $display("FAIL ss_ramp_state: got %0d step %0d", state_out, i); end
        end
        cur_duty = 20;
    endtask
`else
    task automatic test_enable_run;
        duty_in = 10'd512; duty_valid = 1'b1;
        @(negedge clk);
        duty_valid = 1'b0; enable = 1'b1;
        @(negedge clk);
        checks++; if (state_out !== 2'd2) begin errors++; $display("FAIL run_entry_state: got %0d exp 2", state_out); end
        checks++; if (duty_out !== 10'd512) begin errors++; $display("FAIL run_entry_duty: got %0d exp 512", duty_out); end
        checks++; if (cnt_out !== 10'd0 || period_start !== 1'b1) begin errors++; $display("FAIL run_entry_cnt: cnt %0d pstart %0b exp 0/1", cnt_out, period_start); end
        @(negedge clk);
        checks++; if (cnt_out !== 10'd1 || period_start !== 1'b0) begin errors++; $display("FAIL run_count: cnt %0d pstart %0b exp 1/0", cnt_out, period_start); end
        wait_cnt(P_MAX, 1100);
        @(negedge clk);
        checks++; if (cnt_out !== 10'd0 || period_start !== 1'b1) begin errors++; $display("FAIL run_wrap: cnt %0d pstart %0b exp 0/1", cnt_out, period_start); end
        checks++; if (duty_out !== 10'd512) begin errors++; $display("FAIL run_hold_duty: got %0d exp 512", duty_out); end
        cur_duty = 512;
    endtask
`endif

    task automatic test_deferred_update;
        wait_cnt(10, 1100);
        duty_in = 10'd300; duty_valid = 1'b1;
        @(negedge clk);
        duty_valid = 1'b0;
        checks++; if (duty_ready !== 1'b0) begin errors++; $display("FAIL defer_ready_low: got %0b exp 0", duty_ready); end
        checks++; if (duty_out !== 10'(cur_duty)) begin errors++; $display("FAIL defer_mid: got %0d exp %0d", duty_out, cur_duty); end
        wait_cnt(P_MAX, 1100);
        checks++; if (duty_out !== 10'(cur_duty) || duty_ready !== 1'b0) begin errors++; $display("FAIL defer_last: duty %0d ready %0b exp %0d/0", duty_out, duty_ready, cur_duty); end
        @(negedge clk);
        checks++; if (duty_out !== 10'd300) begin errors++; $display("FAIL defer_apply: got %0d exp 300", duty_out); end
        checks++; if (duty_ready !== 1'b1) begin errors++; $display("FAIL defer_ready_back: got %0b exp 1", duty_ready); end
        cur_duty = 300;
    endtask

    task automatic test_accept_at_wrap;
        wait_cnt(P_MAX, 1100);
        duty_in = 10'd700; duty_valid = 1'b1;
        @(negedge clk);
        duty_valid = 1'b0;
        checks++; if (duty_out !== 10'(cur_duty)) begin errors++; $display("FAIL wrap_accept_hold: got %0d exp %0d", duty_out, cur_duty); end
        checks++; if (duty_ready !== 1'b0) begin errors++; $display("FAIL wrap_accept_ready: got %0b exp 0", duty_ready); end
        wait_cnt(P_MAX, 1100);
        @(negedge clk);
        checks++; if (duty_out !== 10'd700) begin errors++; $display("FAIL wrap_accept_apply: got %0d exp 700", duty_out); end
    endtask

    task automatic test_full_on;
        wait_cnt(500, 1100);
        duty_in = 10'd1023; duty_valid = 1'b1;
        @(negedge clk);
        duty_valid = 1'b0;
        wait_cnt(P_MAX, 1100);
        @(negedge clk);
        checks++; if (duty_out !== 10'd1023) begin errors++; $display("FAIL full_on: got %0d exp 1023", duty_out); end
    endtask

    task automatic test_disable;
        int n = 0;
        wait_cnt(37, 1100);
        enable = 1'b0;
        @(negedge clk);
        checks++; if (state_out !== 2'd0 || duty_out !== 10'd0 || cnt_out !== 10'd0) begin
            errors++; $display("FAIL disable: state %0d duty %0d cnt %0d exp 0/0/0", state_out, duty_out, cnt_out);
        end
        duty_in = 10'd16; duty_valid = 1'b1;
        @(negedge clk);
        duty_valid = 1'b0; enable = 1'b1;
        @(negedge clk);
        checks++; if (state_out !== 2'(ENTRY_STATE)) begin errors++; $display("FAIL reenable_state: got %0d exp %0d", state_out, ENTRY_STATE); end
        while (state_out !== 2'd2 && n < 2200) begin @(negedge clk); n++; end
        checks++; if (state_out !== 2'd2 || duty_out !== 10'd16) begin
            errors++; $display("FAIL reach_run: state %0d duty %0d exp 2/16", state_out, duty_out);
        end
    endtask

    task automatic test_fault;
        int exp_entry = (ENTRY_STATE == 2) ? 16 : 0;
        wait_cnt(200, 1100);
        fault = 1'b1;
        @(negedge clk);
        fault = 1'b0;
        checks++; if (state_out !== 2'd3) begin errors++; $display("FAIL fault_state: got %0d exp 3", state_out); end
        checks++; if (duty_out !== 10'd0 || cnt_out !== 10'd0) begin errors++; $display("FAIL fault_zero: duty %0d cnt %0d exp 0/0", duty_out, cnt_out); end
        checks++; if (duty_ready !== 1'b0) begin errors++; $display("FAIL fault_ready: got %0b exp 0", duty_ready); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (state_out !== 2'd3) begin errors++; $display("FAIL fault_hold: got %0d exp 3", state_out); end
        end
        enable = 1'b0;
        @(negedge clk);
        checks++; if (state_out !== 2'd0 || duty_ready !== 1'b1) begin errors++; $display("FAIL fault_exit: state %0d ready %0b exp 0/1", state_out, duty_ready); end
        enable = 1'b1;
        @(negedge clk);
        checks++; if (state_out !== 2'(ENTRY_STATE) || duty_out !== 10'(exp_entry)) begin
            errors++; $display("FAIL fault_restart: state %0d duty %0d exp %0d/%0d", state_out, duty_out, ENTRY_STATE, exp_entry);
        end
    endtask

    task automatic test_random;
        int prints = 0;
        int pick;
        bit exp_ps;
        for (int cyc = 0; cyc < 7000; cyc++) begin
            @(negedge clk);
            exp_ps = (m_state == 1 || m_state == 2) && (m_cnt == 0);
            checks++;
            if (state_out !== 2'(m_state) || cnt_out !== 10'(m_cnt) || duty_out !== 10'(m_duty) ||
                duty_ready !== m_ready || period_start !== exp_ps) begin
                errors++;
                if (prints < 10) begin
                    prints++;
                    $display("FAIL random cyc %0d: got st%0d cnt%0d duty%0d rdy%0b ps%0b exp st%0d cnt%0d duty%0d rdy%0b ps%0b",
                             cyc, state_out, cnt_out, duty_out, duty_ready, period_start,
                             m_state, m_cnt, m_duty, m_ready, exp_ps);
                end
            end
            pick = int'($urandom_range(0, 5));
            case (pick)
                0: duty_in = 10'd0;
                1: duty_in = 10'd1023;
                2: duty_in = 10'($urandom_range(0, 40));
                default: duty_in = 10'($urandom_range(0, 1023));
            endcase
            duty_valid = ($urandom_range(0, 3) == 0) || (cnt_out == 10'd1023 && $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 699) == 0) enable = ~enable;
            fault = ($urandom_range(0, 1999) == 0);
            reset = (cyc >= 3500 && cyc < 3502);
        end
        duty_valid = 1'b0; fault = 1'b0; reset = 1'b0;
    endtask

    task automatic test_clamp;
        int n = 0;
        c_reset = 1'b1; c_enable = 1'b0; c_valid = 1'b0; c_duty_in = '0;
        repeat (2) @(negedge clk);
        c_reset = 1'b0;
        @(negedge clk);
        checks++; if (c_ready !== 1'b1) begin errors++; $display("FAIL clamp_ready: got %0b exp 1", c_ready); end
        c_duty_in = 11'd1100; c_valid = 1'b1;
        @(negedge clk);
        c_valid = 1'b0; c_enable = 1'b1;
        while (c_state !== 2'd2 && n < 4000) begin @(negedge clk); n++; end
        checks++; if (c_state !== 2'd2 || c_duty_out !== 11'd1000) begin
            errors++; $display("FAIL clamp_duty: state %0d duty %0d exp 2/1000", c_state, c_duty_out);
        end
    endtask

    initial begin
        c_reset = 1'b1; c_enable = 1'b0; c_valid = 1'b0; c_duty_in = '0;
        test_reset();
        test_enable_run();
        test_deferred_update();
        test_accept_at_wrap();
        test_full_on();
        test_disable();
        test_fault();
        test_random();
        test_clamp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
